// File: rtl/motion_zone_tracker.sv
// Per-strip motion pixel counter with frame-end arg-max scan, min-pixel gate and debounce.
// Optional build macro ZONE_MIRROR_EN: zone 0 is the leftmost strip instead of the rightmost.
module motion_zone_tracker #(
  parameter int N_ZONES       = 7,
  parameter int ZONE_W        = 114,
  parameter int H_ACT         = 800,
  parameter int V_ACT         = 600,
  parameter int X_START       = 216,
  parameter int Y_START       = 27,
  parameter int COLOR_W       = 10,
  parameter int PIX_THRESH    = 200,
  parameter int MIN_PIXELS    = 600,
  parameter int CNT_W         = 18,
  parameter int DIR_W         = 3,
  parameter int STABLE_FRAMES = 3
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [12:0]        iH_Cont,
  input  logic [12:0]        iV_Cont,
  input  logic [COLOR_W-1:0] iColorVal,
  output logic [DIR_W-1:0]   oDirection,
  output logic               oMotion,
  output logic [CNT_W-1:0]   oPeak,
  output logic               oFrameDone
);

  localparam int RW = $clog2(STABLE_FRAMES + 1);
  localparam logic [12:0]        XS     = 13'(X_START);
  localparam logic [12:0]        XE     = 13'(X_START + H_ACT - 1);
  localparam logic [12:0]        YS     = 13'(Y_START);
  localparam logic [12:0]        YE     = 13'(Y_START + V_ACT - 1);
  localparam logic [12:0]        ZLAST  = 13'(ZONE_W - 1);
  localparam logic [DIR_W-1:0]   PLAST  = DIR_W'(N_ZONES - 1);
  localparam logic [DIR_W-1:0]   NONE   = '1;
  localparam logic [COLOR_W-1:0] THR    = COLOR_W'(PIX_THRESH);
  localparam logic [RW-1:0]      RUNMAX = RW'(STABLE_FRAMES);
  localparam logic [31:0]        MINP   = 32'(MIN_PIXELS);

  typedef enum logic [1:0] {ACCUM, SCAN, COMMIT} state_t;
  state_t state, nxt;

  logic [N_ZONES-1:0][CNT_W-1:0] cnt;
  logic [12:0]      offR, curOff;
  logic [DIR_W-1:0] pR, curP, zone;
  logic [DIR_W-1:0] scanIdx, bestIdx, bestIdxN, result, cand, candN, dirN;
  logic [CNT_W-1:0] bestCnt, bestCntN, curCnt;
  logic [RW-1:0]    run, runN;
  logic             active, finalPix, qual, take, commitEdge;

  assign active     = (iH_Cont >= XS) && (iH_Cont <= XE) && (iV_Cont >= YS) && (iV_Cont <= YE);
  assign finalPix   = (iH_Cont == XE) && (iV_Cont == YE);
  assign qual       = iColorVal > THR;
  assign commitEdge = (state == SCAN) && (scanIdx == PLAST);

  // Physical strip (0 = leftmost) tracked by counting, restarted at the line's first pixel.
  always_comb begin
    curOff = offR;
    curP   = pR;
    if (iH_Cont == XS) begin
      curOff = '0;
      curP   = '0;
    end
`ifdef ZONE_MIRROR_EN
    zone = curP;
`else
    zone = PLAST - curP;
`endif
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      offR <= '0;
      pR   <= '0;
    end else if (active) begin
      if (curOff == ZLAST && curP != PLAST) begin
        offR <= '0;
        pR   <= curP + 1'b1;
      end else begin
        offR <= curOff + 1'b1;
        pR   <= curP;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt <= '0;
    end else if (state == ACCUM) begin
      if (iV_Cont < YS)
        cnt <= '0;
      else if (active && qual && cnt[zone] != '1)
        cnt[zone] <= cnt[zone] + 1'b1;
    end else if (state == COMMIT) begin
      cnt <= '0;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      ACCUM:   if (finalPix) nxt = SCAN;
      SCAN:    if (scanIdx == PLAST) nxt = COMMIT;
      COMMIT:  nxt = ACCUM;
      default: nxt = ACCUM;
    endcase
  end

  // Index 0 always seeds the scan; later zones win only when strictly greater.
  always_comb begin
    curCnt   = cnt[scanIdx];
    take     = (scanIdx == '0) || (curCnt > bestCnt);
    bestCntN = take ? curCnt : bestCnt;
    bestIdxN = take ? scanIdx : bestIdx;
    result   = (32'(bestCntN) >= MINP) ? bestIdxN : NONE;
    candN    = result;
    runN     = RW'(1);
    if (result == cand) begin
      candN = cand;
      runN  = (run == RUNMAX) ? RUNMAX : run + 1'b1;
    end
    dirN = (runN == RUNMAX) ? candN : oDirection;
  end

  // Results register on the last scan edge so they are visible during the COMMIT cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= ACCUM;
      scanIdx    <= '0;
      bestCnt    <= '0;
      bestIdx    <= '0;
      cand       <= NONE;
      run        <= '0;
      oDirection <= NONE;
      oMotion    <= 1'b0;
      oPeak      <= '0;
      oFrameDone <= 1'b0;
    end else begin
      state      <= nxt;
      oFrameDone <= commitEdge;
      if (state == SCAN && !commitEdge) begin
        scanIdx <= scanIdx + 1'b1;
        bestCnt <= bestCntN;
        bestIdx <= bestIdxN;
      end else begin
        scanIdx <= '0;
      end
      if (commitEdge) begin
        cand       <= candN;
        run        <= runN;
        oPeak      <= bestCntN;
        oDirection <= dirN;
        oMotion    <= (dirN != NONE);
      end
    end
  end

endmodule

// File: doc/motion_zone_tracker.md
# motion_zone_tracker

Parametrised successor to the camera-path horizontal motion-direction estimator. Splits the active raster into `N_ZONES` vertical strips and counts per strip the pixels whose motion/colour value exceeds a threshold. At frame end it runs a sequential arg-max scan, applies a minimum-pixel gate and an N-frame debounce, and publishes a stable direction code plus peak count. Sits beside the VGA timing generator, fed by its `iH_Cont`/`iV_Cont` counters and the per-pixel motion value.

## Interface
- `N_ZONES`, 7: number of strips; must satisfy 2 ≤ N_ZONES ≤ 2^DIR_W − 1
- `ZONE_W`, 114: strip width in pixels; last strip absorbs remainder H_ACT − (N_ZONES−1)·ZONE_W (must be ≥ 1)
- `H_ACT`, 800 / `V_ACT`, 600: active pixels / lines
- `X_START`, 216 / `Y_START`, 27: first active H / V count
- `COLOR_W`, 10: pixel value width
- `PIX_THRESH`, 200: pixel qualifies when value > PIX_THRESH (strict)
- `MIN_PIXELS`, 600: winner valid only if its count ≥ MIN_PIXELS
- `CNT_W`, 18: zone counter width, saturating
- `DIR_W`, 3: direction code width; NONE = all ones
- `STABLE_FRAMES`, 3: consecutive identical frame results needed before output changes (≥ 1)
- `iCLK` in 1: pixel clock
- `iRST_N` in 1: asynchronous, active-low reset
- `iH_Cont` in 13: horizontal counter
- `iV_Cont` in 13: vertical counter
- `iColorVal` in COLOR_W: per-pixel motion value
- `oDirection` out DIR_W: debounced zone index, or NONE
- `oMotion` out 1: registered, equals (oDirection ≠ NONE)
- `oPeak` out CNT_W: winning zone's count from the last evaluated frame
- `oFrameDone` out 1: one-cycle pulse when a frame result commits

## Operation
- Active pixel: X_START ≤ iH_Cont < X_START+H_ACT and Y_START ≤ iV_Cont < Y_START+V_ACT.
- Zone tracking is sequential with no divider. At iH_Cont == X_START, zone = 0 and offset = 0. Each active pixel increments offset. When offset == ZONE_W−1 and zone < N_ZONES−1, offset wraps to 0 and zone increments.
- Qualifying active pixel in ACCUM: count[zone] += 1, saturating at 2^CNT_W − 1.
- FSM states are ACCUM, SCAN and COMMIT.
  - ACCUM: counting. While iV_Cont < Y_START, all counts are held at 0. On the final active pixel (iV_Cont == Y_START+V_ACT−1, iH_Cont == X_START+H_ACT−1), that pixel is counted and the next state is SCAN.
  - SCAN: exactly N_ZONES cycles, examining count[0..N_ZONES−1] in order. best is replaced only on strictly greater, so a tie goes to the lowest index. No counting during SCAN.
  - COMMIT: one cycle.
    - result = best_idx if best_cnt ≥ MIN_PIXELS, else NONE.
    - oPeak ← best_cnt and oFrameDone = 1.
    - All counts are cleared, and the FSM returns to ACCUM.
- Debounce, applied in COMMIT:
  - If result == cand, run ← min(run+1, STABLE_FRAMES); otherwise cand ← result and run ← 1.
  - If the new run == STABLE_FRAMES, oDirection ← cand.
  - With STABLE_FRAMES = 1, every frame's result is published directly.
- oMotion is registered from the same next-state value as oDirection.

## Timing
- Reset values: oDirection = NONE, oMotion = 0, oPeak = 0, oFrameDone = 0. Counts, cand = NONE, run = 0, state = ACCUM.
- oFrameDone asserts N_ZONES+1 cycles after the final-pixel cycle. oDirection, oMotion and oPeak update on the same edge.
- Boundary cases:
  - The final-pixel condition is ignored outside ACCUM.
  - Counters at saturation stay saturated.
  - A frame that is partial because reset was released mid-frame is evaluated normally.
  - Reset asserted mid-SCAN aborts immediately with no commit.
  - The last zone is width-checked only by the active-region bound.
- Scan and commit must finish within vertical blanking, which requires N_ZONES+2 < blanking length. This holds for all supported timings.

## Configuration
- `ZONE_MIRROR_EN` undefined: zone 0 = rightmost strip (mirrored camera, legacy numbering); the first active pixel of a line lands in zone N_ZONES−1.
- `ZONE_MIRROR_EN` defined: zone 0 = leftmost strip; the first active pixel lands in zone 0.
- Scan order, tie rule and codes are unchanged; only the index mapping flips.

## Test plan
- Reset, no stimulus → oDirection = 7, oMotion = 0, oPeak = 0. With idle frames, oFrameDone pulses once per frame and outputs stay unchanged.
- Defaults (macro off), value 255 in H offsets 0..113 for 10 lines (1140 px), three frames → oPeak = 1140 each frame, oDirection = 6 and oMotion = 1 only after the third oFrameDone.
- 500 qualifying px in one zone → NONE, oMotion = 0. Value exactly 200 everywhere → all counts 0.
- Equal 1000-px counts in zones 2 and 4 → result 2. Alternating winners 1, 3, 1, 3 → oDirection never leaves its prior value.
- `ZONE_MIRROR_EN` defined, hits at H offset 799 → oDirection = 6. Hits at offset 0 → 0.
- iRST_N pulsed during SCAN → no oFrameDone for that frame, outputs at reset values. Next full frame evaluates correctly. Counter forced past 2^18−1 reads 262143.
